// File: rtl/wb_decoder.sv
// Single-master, three-slave Wishbone B4 classic-cycle interconnect: decodes the
// master address, latches the selected slave and terminates unmapped/hung accesses with err.
module wb_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_C000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_FF00,
  parameter logic [31:0] S2_BASE = 32'h0001_0100,
  parameter logic [31:0] S2_MASK = 32'hFFFF_FF00,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic [31:0] m_adr_i,
  input  logic [3:0]  m_sel_i,
  input  logic [31:0] m_dat_i,
  output logic [31:0] m_dat_o,
  output logic        m_ack_o,
  output logic        m_err_o,
  output logic        m_rty_o,
  output logic        m_stall_o,
  output logic [2:0]  s_cyc_o,
  output logic [2:0]  s_stb_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  input  logic [95:0] s_dat_i,
  input  logic [2:0]  s_ack_i,
  input  logic [2:0]  s_err_i,
  input  logic [2:0]  s_rty_i,
  input  logic [2:0]  s_stall_i
);

  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] DECERR = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [2:0]  match;
  logic        hit;
  logic [1:0]  dec_sel;
  logic [2:0]  dec_oh;
  logic [2:0]  busy_oh;
  logic [31:0] busy_dat;
  logic        resp_ack, resp_err, resp_rty;

  assign match = {(m_adr_i & S2_MASK) == S2_BASE,
                  (m_adr_i & S1_MASK) == S1_BASE,
                  (m_adr_i & S0_MASK) == S0_BASE};
  assign hit   = |match;

  // Priority decode: the lowest matching slave index wins.
  always_comb begin
    dec_sel = 2'd0;
    dec_oh  = 3'b000;
    if (match[0]) begin
      dec_sel = 2'd0;
      dec_oh  = 3'b001;
    end else if (match[1]) begin
      dec_sel = 2'd1;
      dec_oh  = 3'b010;
    end else if (match[2]) begin
      dec_sel = 2'd2;
      dec_oh  = 3'b100;
    end
  end

  // One-hot view and read-data lane of the latched slave.
  always_comb begin
    busy_oh  = 3'b000;
    busy_dat = '0;
    case (sel_q)
      2'd0: begin busy_oh = 3'b001; busy_dat = s_dat_i[31:0];  end
      2'd1: begin busy_oh = 3'b010; busy_dat = s_dat_i[63:32]; end
      2'd2: begin busy_oh = 3'b100; busy_dat = s_dat_i[95:64]; end
      default: ;
    endcase
  end

  // Responses count only from the latched slave while the master holds cyc.
  assign resp_ack = m_cyc_i & |(s_ack_i & busy_oh);
  assign resp_err = m_cyc_i & |(s_err_i & busy_oh);
  assign resp_rty = m_cyc_i & |(s_rty_i & busy_oh);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    s_cyc_o   = 3'b000;
    s_stb_o   = 3'b000;
    m_ack_o   = 1'b0;
    m_err_o   = 1'b0;
    m_rty_o   = 1'b0;
    m_stall_o = 1'b0;
    m_dat_o   = '0;

    case (state_q)
      IDLE: begin
        m_stall_o = |(s_stall_i & dec_oh);
        if (m_cyc_i && m_stb_i) begin
          if (hit) begin
            s_cyc_o = dec_oh;
            s_stb_o = dec_oh;
            state_d = BUSY;
            sel_d   = dec_sel;
            timer_d = '0;
          end else begin
            state_d = DECERR;
          end
        end
      end
      BUSY: begin
        m_stall_o = |(s_stall_i & busy_oh);
        s_cyc_o   = m_cyc_i ? busy_oh : 3'b000;
        s_stb_o   = (m_cyc_i && m_stb_i) ? busy_oh : 3'b000;
        m_ack_o   = resp_ack;
        m_err_o   = resp_err;
        m_rty_o   = resp_rty;
        m_dat_o   = resp_ack ? busy_dat : '0;
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (resp_ack || resp_err || resp_rty) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_q == TIMER_LAST) state_d = DECERR;
        end
      end
      DECERR: begin
        m_err_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every slave strobe and master response immediately.
    if (!rst_ni) begin
      s_cyc_o   = 3'b000;
      s_stb_o   = 3'b000;
      m_ack_o   = 1'b0;
      m_err_o   = 1'b0;
      m_rty_o   = 1'b0;
      m_stall_o = 1'b0;
      m_dat_o   = '0;
    end
  end

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;

endmodule

// File: tb/tb_wb_decoder.sv
// Bench for wb_decoder: directed scenarios plus randomized traffic checked against
// a transaction-level reference model of the decoder.
module tb_wb_decoder;
  localparam int unsigned TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m_cyc_i, m_stb_i, m_we_i;
  logic [31:0] m_adr_i, m_dat_i;
  logic [3:0]  m_sel_i;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_err_o, m_rty_o, m_stall_o;
  logic [2:0]  s_cyc_o, s_stb_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic [95:0] s_dat_i;
  logic [2:0]  s_ack_i, s_err_i, s_rty_i, s_stall_i;

  always #5 clk_i = ~clk_i;

  wb_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .s_stall_i(s_stall_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction in flight, its target, and how long it has waited.
  bit in_txn, err_beat;
  int target, waited;
  bit n_in_txn, n_err_beat;
  int n_target, n_waited;
  logic [2:0]  e_cyc, e_stb;
  logic        e_ack, e_err, e_rty, e_stall;
  logic [31:0] e_dat;

  function automatic int region(input logic [31:0] a);
    if (a < 32'h0000_4000) return 0;
    if (a >= 32'h0001_0000 && a < 32'h0001_0100) return 1;
    if (a >= 32'h0001_0100 && a < 32'h0001_0200) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    in_txn = 0; err_beat = 0; target = 0; waited = 0;
  endtask

  task automatic eval_model();
    int t;
    e_cyc = '0; e_stb = '0; e_ack = 0; e_err = 0; e_rty = 0; e_stall = 0; e_dat = '0;
    n_in_txn = in_txn; n_err_beat = 0; n_target = target; n_waited = waited;
    if (err_beat) begin
      e_err = 1;
    end else if (!in_txn) begin
      t = region(m_adr_i);
      if (t >= 0) e_stall = s_stall_i[t];
      if (m_cyc_i && m_stb_i) begin
        if (t >= 0) begin
          e_cyc[t] = 1; e_stb[t] = 1;
          n_in_txn = 1; n_target = t; n_waited = 0;
        end else begin
          n_err_beat = 1;
        end
      end
    end else begin
      e_stall = s_stall_i[target];
      if (!m_cyc_i) begin
        n_in_txn = 0;
      end else begin
        e_cyc[target] = 1;
        e_stb[target] = m_stb_i;
        e_ack = s_ack_i[target];
        e_err = s_err_i[target];
        e_rty = s_rty_i[target];
        if (e_ack) e_dat = s_dat_i[target*32 +: 32];
        if (e_ack || e_err || e_rty) begin
          n_in_txn = 0;
        end else begin
          n_waited = waited + 1;
          if (n_waited == TIMEOUT) begin
            n_in_txn = 0; n_err_beat = 1;
          end
        end
      end
    end
  endtask

  // Called at a negedge with inputs set; checks all outputs, advances to next negedge.
  task automatic step();
    #1;
    eval_model();
    check("s_cyc", 128'(s_cyc_o), 128'(e_cyc));
    check("s_stb", 128'(s_stb_o), 128'(e_stb));
    check("m_resp", 128'({m_ack_o, m_err_o, m_rty_o, m_stall_o}),
          128'({e_ack, e_err, e_rty, e_stall}));
    check("m_dat", 128'(m_dat_o), 128'(e_dat));
    check("bcast", 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o}),
          128'({m_adr_i, m_dat_i, m_sel_i, m_we_i}));
    @(posedge clk_i);
    in_txn = n_in_txn; err_beat = n_err_beat; target = n_target; waited = n_waited;
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0; s_stall_i = '0;
  endtask

  task automatic rand_inputs(input int unsigned resp_pct);
    int unsigned r;
    m_cyc_i = ($urandom_range(0, 7) != 0);
    m_stb_i = ($urandom_range(0, 3) != 0);
    m_we_i  = 1'($urandom);
    m_sel_i = 4'($urandom);
    m_dat_i = $urandom;
    r = $urandom_range(0, 4);
    case (r)
      0: m_adr_i = 32'($urandom_range(0, 32'h3FFF));
      1: m_adr_i = 32'h0001_0000 + 32'($urandom_range(0, 255));
      2: m_adr_i = 32'h0001_0100 + 32'($urandom_range(0, 255));
      3: m_adr_i = 32'h0000_4000 + 32'($urandom_range(0, 32'hBFFF));
      default: m_adr_i = $urandom;
    endcase
    for (int k = 0; k < 3; k++) begin
      s_ack_i[k]   = ($urandom_range(0, 99) < resp_pct);
      s_err_i[k]   = ($urandom_range(0, 99) < resp_pct / 4);
      s_rty_i[k]   = ($urandom_range(0, 99) < resp_pct / 4);
      s_stall_i[k] = 1'($urandom);
    end
    s_dat_i = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    idle_inputs();
    rst_ni = 0;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h10;
    s_ack_i = 3'b111; s_stall_i = 3'b111; s_dat_i = {3{32'hFFFF_FFFF}};
    #12;
    check("rst_cyc_stb", 128'({s_cyc_o, s_stb_o}), 128'(0));
    check("rst_resp", 128'({m_ack_o, m_err_o, m_rty_o, m_stall_o}), 128'(0));
    check("rst_dat", 128'(m_dat_o), 128'(0));
    idle_inputs();
    rst_ni = 1;
    model_reset();
    @(negedge clk_i);

    // Slave-0 read, ack one cycle after the strobe.
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0000_0010;
    #1 check("rd_stb", 128'(s_stb_o), 128'(3'b001));
    step();
    s_ack_i = 3'b001; s_dat_i[31:0] = 32'hDEAD_BEEF;
    #1 check("rd_ack", 128'({m_ack_o, s_stb_o}), 128'({1'b1, 3'b001}));
    check("rd_dat", 128'(m_dat_o), 128'(32'hDEAD_BEEF));
    step();
    idle_inputs();
    step();

    // Slave-1 write, strobe held through the ack cycle.
    m_cyc_i = 1; m_stb_i = 1; m_we_i = 1; m_adr_i = 32'h0001_0004; m_dat_i = 32'h1234_5678;
    #1 check("wr_stb", 128'(s_stb_o), 128'(3'b010));
    check("wr_dat", 128'(s_dat_o), 128'(32'h1234_5678));
    step();
    s_ack_i = 3'b010;
    #1 check("wr_ack", 128'({m_ack_o, s_stb_o}), 128'({1'b1, 3'b010}));
    step();
    idle_inputs();
    #1 check("wr_ack_once", 128'(m_ack_o), 128'(0));
    step();

    // Unmapped access: err in the following cycle only.
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h8000_0000;
    #1 check("um_c1", 128'({s_stb_o, m_err_o, m_ack_o}), 128'(0));
    step();
    #1 check("um_c2", 128'({s_stb_o, m_err_o, m_ack_o}), 128'({3'b000, 1'b1, 1'b0}));
    step();
    idle_inputs();
    #1 check("um_c3", 128'(m_err_o), 128'(0));
    step();

    // Slave 2 never responds: timeout err, then a late ack is dropped.
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0001_0100;
    #1 check("to_stb", 128'(s_stb_o), 128'(3'b100));
    step();
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      #1 check("to_wait", 128'(m_err_o), 128'(0));
      step();
    end
    #1 check("to_err", 128'({m_err_o, s_stb_o}), 128'({1'b1, 3'b000}));
    step();
    m_stb_i = 0; s_ack_i = 3'b100;
    #1 check("to_late", 128'({m_ack_o, m_err_o}), 128'(0));
    step();
    idle_inputs();
    step();

    // Master abort in the second BUSY cycle, then a slave-0 read.
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0001_0008;
    step();
    step();
    m_cyc_i = 0; m_stb_i = 0; s_ack_i = 3'b010;
    #1 check("ab_drop", 128'({s_cyc_o, s_stb_o, m_ack_o}), 128'(0));
    step();
    s_ack_i = '0; m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0000_0020;
    #1 check("ab_new_stb", 128'({s_cyc_o, s_stb_o}), 128'({3'b001, 3'b001}));
    step();
    s_ack_i = 3'b001; s_dat_i[31:0] = 32'hCAFE_0001;
    #1 check("ab_new_ack", 128'({m_ack_o, m_dat_o}), 128'({1'b1, 32'hCAFE_0001}));
    step();
    idle_inputs();
    step();

    // Reset pulse mid-BUSY aborts silently; the next request decodes normally.
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0001_0040;
    step();
    s_stall_i = 3'b111;
    #1 check("mr_busy", 128'({s_stb_o, m_stall_o}), 128'({3'b010, 1'b1}));
    s_ack_i = 3'b010; s_dat_i = {3{32'h5555_AAAA}};
    rst_ni = 0;
    #1 check("mr_zero", 128'({s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, m_stall_o, m_dat_o}),
             128'(0));
    idle_inputs();
    #1 rst_ni = 1;
    model_reset();
    @(negedge clk_i);
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0001_0180;
    #1 check("mr_new_stb", 128'(s_stb_o), 128'(3'b100));
    step();
    s_ack_i = 3'b100; s_dat_i[95:64] = 32'h0BAD_F00D;
    #1 check("mr_new_ack", 128'({m_ack_o, m_dat_o}), 128'({1'b1, 32'h0BAD_F00D}));
    step();
    idle_inputs();
    step();

    // Randomized traffic: busy responders, then sparse ones to provoke timeouts.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(30);
      step();
    end
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(4);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
